// File: rtl/display_scan_ctrl_if.sv
// Purpose: bundle of value/control inputs and scan outputs for the display scan controller.
// Latency: none, plain wires. Backpressure: none, load is a fire-and-forget strobe.
interface display_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [3:0]  an_o;
    logic [3:0]  nibble_o;
    logic        pending_o;
    logic        frame_o;

    modport master (
        output en, load, data_in, blank_mask, lz_en,
        input  an_o, nibble_o, pending_o, frame_o
    );

    modport slave (
        input  en, load, data_in, blank_mask, lz_en,
        output an_o, nibble_o, pending_o, frame_o
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Purpose: 4-digit seven-segment scan with frame-aligned double-buffered value updates.
// Latency: an_o/nibble_o registered one cycle after digit index; new value shows after next frame wrap.
// Backpressure: none; load always accepted, last load before a wrap wins.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input logic              clk,
    input logic              rst_n,
    display_scan_ctrl_if.slave bus
);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    logic [15:0]      disp;
    logic             pending;
    logic [3:0]       an_q;
    logic [3:0]       nibble_q;

    logic             tick;
    logic             wrap;
    logic [3:0]       lz;
    logic             blank;
    logic [3:0]       sel_nibble;

    assign tick = bus.en && (cnt == CNT_W'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (!bus.en) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 16'h0000;
        end else if (bus.load) begin
            shadow <= bus.data_in;
        end
    end

    // While dark the display follows the input directly, including a load in the same cycle.
    // At a wrap the pre-edge shadow is committed; a coincident load stays pending for the next wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp    <= 16'h0000;
            pending <= 1'b0;
        end else if (!bus.en) begin
            disp    <= bus.load ? bus.data_in : shadow;
            pending <= 1'b0;
        end else if (wrap && pending) begin
            disp    <= shadow;
            pending <= bus.load;
        end else if (bus.load) begin
            pending <= 1'b1;
        end
    end

    always_comb begin
        lz    = 4'b0000;
        lz[3] = (disp[15:12] == 4'h0);
        lz[2] = lz[3] && (disp[11:8] == 4'h0);
        lz[1] = lz[2] && (disp[7:4] == 4'h0);
    end

    always_comb begin
        sel_nibble = disp[3:0];
        case (idx)
            2'd0: sel_nibble = disp[3:0];
            2'd1: sel_nibble = disp[7:4];
            2'd2: sel_nibble = disp[11:8];
            2'd3: sel_nibble = disp[15:12];
            default: sel_nibble = disp[3:0];
        endcase
    end

    assign blank = bus.blank_mask[idx] || (bus.lz_en && lz[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q     <= 4'b1111;
            nibble_q <= 4'h0;
        end else if (!bus.en) begin
            an_q     <= 4'b1111;
            nibble_q <= 4'h0;
        end else begin
            an_q     <= blank ? 4'b1111 : ~(4'b0001 << idx);
            nibble_q <= sel_nibble;
        end
    end

    assign bus.an_o      = an_q;
    assign bus.nibble_o  = nibble_q;
    assign bus.pending_o = pending;
    assign bus.frame_o   = wrap;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with REFRESH_DIV=4: frame-aligned updates,
// wrap-coincident load, leading-zero suppression, blanking, disabled mode and async reset.
module tb_display_scan_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.REFRESH_DIV(4), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until frame_o is seen (state just before the wrap edge).
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step(1);
            if (bus.frame_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $error("FAIL %s frame_o timeout observed=0 expected=1", tag);
        end
    endtask

    task automatic load_val(input logic [15:0] v);
        bus.load    = 1'b1;
        bus.data_in = v;
        step(1);
        bus.load    = 1'b0;
    endtask

    // Load a value and land on the first cycle showing digit 0 of the frame that displays it.
    task automatic show(input string tag, input logic [15:0] v);
        load_val(v);
        wait_frame(tag);
        step(2);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] nib, input logic [3:0] an);
        check({tag, ".nibble"}, {12'h0, bus.nibble_o}, {12'h0, nib});
        check({tag, ".an"},     {12'h0, bus.an_o},     {12'h0, an});
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.load       = 1'b0;
        bus.data_in    = 16'h0000;
        bus.blank_mask = 4'b0000;
        bus.lz_en      = 1'b0;
        step(3);
        check("reset.an",      {12'h0, bus.an_o},     16'h000F);
        check("reset.nibble",  {12'h0, bus.nibble_o}, 16'h0000);
        check("reset.pending", {15'h0, bus.pending_o}, 16'h0000);
        check("reset.frame",   {15'h0, bus.frame_o},   16'h0000);
        rst_n = 1'b1;
        step(1);

        // 1: first value appears in the frame after the first wrap
        bus.en = 1'b1;
        load_val(16'h1234);
        check("t1.pending_set", {15'h0, bus.pending_o}, 16'h0001);
        wait_frame("t1.frame");
        check("t1.pending_at_wrap", {15'h0, bus.pending_o}, 16'h0001);
        step(1);
        check("t1.pending_clr", {15'h0, bus.pending_o}, 16'h0000);
        step(1);
        chk_out("t1.d0", 4'h4, 4'b1110);
        step(3);
        chk_out("t1.d0_hold", 4'h4, 4'b1110);
        step(1);
        chk_out("t1.d1", 4'h3, 4'b1101);
        step(4);
        chk_out("t1.d2", 4'h2, 4'b1011);
        step(4);
        chk_out("t1.d3", 4'h1, 4'b0111);

        // 2: load in digit-1 slot does not disturb the current frame
        show("t2.frame_a", 16'hABCD);
        chk_out("t2.d0", 4'hD, 4'b1110);
        step(4);
        chk_out("t2.d1", 4'hC, 4'b1101);
        load_val(16'h5678);
        check("t2.pending", {15'h0, bus.pending_o}, 16'h0001);
        step(3);
        chk_out("t2.d2_old", 4'hB, 4'b1011);
        step(4);
        chk_out("t2.d3_old", 4'hA, 4'b0111);
        step(2);
        check("t2.frame", {15'h0, bus.frame_o}, 16'h0001);
        step(2);
        chk_out("t2.d0_new", 4'h8, 4'b1110);
        check("t2.pending_clr", {15'h0, bus.pending_o}, 16'h0000);
        step(4);
        chk_out("t2.d1_new", 4'h7, 4'b1101);
        step(4);
        chk_out("t2.d2_new", 4'h6, 4'b1011);
        step(4);
        chk_out("t2.d3_new", 4'h5, 4'b0111);

        // 3: load coincident with the wrap while another value is pending
        load_val(16'h1111);
        wait_frame("t3.frame_a");
        bus.load    = 1'b1;
        bus.data_in = 16'h0000;
        step(1);
        bus.load    = 1'b0;
        check("t3.pending_kept", {15'h0, bus.pending_o}, 16'h0001);
        step(1);
        chk_out("t3.d0_1111", 4'h1, 4'b1110);
        step(12);
        chk_out("t3.d3_1111", 4'h1, 4'b0111);
        wait_frame("t3.frame_b");
        step(2);
        chk_out("t3.d0_0000", 4'h0, 4'b1110);
        check("t3.pending_clr", {15'h0, bus.pending_o}, 16'h0000);
        step(12);
        chk_out("t3.d3_0000", 4'h0, 4'b0111);

        // 4: leading-zero suppression
        bus.lz_en = 1'b1;
        show("t4.frame_a", 16'h0070);
        chk_out("t4.d0", 4'h0, 4'b1110);
        step(4);
        chk_out("t4.d1", 4'h7, 4'b1101);
        step(4);
        chk_out("t4.d2_dark", 4'h0, 4'b1111);
        step(4);
        chk_out("t4.d3_dark", 4'h0, 4'b1111);
        show("t4.frame_b", 16'h0000);
        chk_out("t4.zero_d0", 4'h0, 4'b1110);
        step(4);
        chk_out("t4.zero_d1", 4'h0, 4'b1111);
        step(4);
        chk_out("t4.zero_d2", 4'h0, 4'b1111);
        step(4);
        chk_out("t4.zero_d3", 4'h0, 4'b1111);

        // 5: explicit blank mask
        bus.lz_en      = 1'b0;
        bus.blank_mask = 4'b0101;
        show("t5.frame", 16'h9876);
        chk_out("t5.d0_dark", 4'h6, 4'b1111);
        step(4);
        chk_out("t5.d1", 4'h7, 4'b1101);
        step(4);
        chk_out("t5.d2_dark", 4'h8, 4'b1111);
        step(4);
        chk_out("t5.d3", 4'h9, 4'b0111);

        // 6: disabled mode applies loads immediately, then async reset
        bus.blank_mask = 4'b0000;
        bus.en         = 1'b0;
        load_val(16'hFEED);
        chk_out("t6.off", 4'h0, 4'b1111);
        check("t6.pending_off", {15'h0, bus.pending_o}, 16'h0000);
        check("t6.frame_off",   {15'h0, bus.frame_o},   16'h0000);
        bus.en = 1'b1;
        step(1);
        chk_out("t6.on_d0", 4'hD, 4'b1110);
        step(2);
        chk_out("t6.mid_slot", 4'hD, 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t6.async_rst", 4'h0, 4'b1111);
        check("t6.rst_pending", {15'h0, bus.pending_o}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
